// File: rtl/uart_pkg.sv
// Shared UART types and defaults for the transmit serializer and its edge detector.
// Optional even parity is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } tx_state_e;

  localparam int   DEFAULT_DATA_BITS = 8;
  localparam int   DEFAULT_STOP_BITS = 1;
  localparam logic IDLE_LEVEL        = 1'b1;

endpackage

// File: rtl/baud_edge_detect.sv
// Synchronizes the divider's baud_clk into the system domain and emits a one-cycle
// tick per rising edge; the first real synchronized sample after reset only primes it.
module baud_edge_detect
  import uart_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic baud_clk_i,
  output logic baud_tick_o
);

  logic       sync1_q;
  logic       sync2_q;
  logic       prev_q;
  logic [1:0] fill_q;
  logic       primed_q;
  logic       tick_q;

  // fill_q tracks when sync2_q holds a genuine baud_clk sample rather than its reset
  // value, so a line that is already high at reset release cannot look like an edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      fill_q   <= 2'b00;
      primed_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      sync1_q  <= baud_clk_i;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      fill_q   <= {fill_q[0], 1'b1};
      primed_q <= fill_q[1];
      tick_q   <= sync2_q & ~prev_q & primed_q;
    end
  end

  assign baud_tick_o = tick_q;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: serializes one DATA_BITS word per frame, timed by ticks from baud_clk.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int STOP_BITS = DEFAULT_STOP_BITS
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 baud_clk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output tx_state_e            dbg_state
);

  localparam int CNT_W  = $clog2(DATA_BITS + 1);
  localparam int STOP_W = $clog2(STOP_BITS + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic [STOP_W-1:0] LAST_STOP = STOP_W'(STOP_BITS - 1);

  // Handshake: a word is taken on any posedge where tx_valid && tx_ready; tx_ready
  // then stays low until the final stop bit ends, and tx_valid is ignored meanwhile.
  logic                 baud_tick;
  logic                 accept;
  tx_state_e            state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [STOP_W-1:0]    stop_cnt_q;
  logic                 tx_q;
  logic                 tx_d;
  logic                 tx_ready_q;
  logic                 busy_q;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  baud_edge_detect u_edge (
    .clk_i       (clk_in),
    .rst_ni      (rst_n),
    .baud_clk_i  (baud_clk),
    .baud_tick_o (baud_tick)
  );

  assign accept = tx_valid && tx_ready_q;

  always_comb begin
    tx_d = IDLE_LEVEL;
    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_q;
`endif
      default:   tx_d = IDLE_LEVEL;
    endcase
  end

  // tx follows the state register by one cycle; SYNC absorbs any tick that coincides
  // with the accept so the start bit always lasts a full baud period.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      tx_q       <= IDLE_LEVEL;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      tx_q <= tx_d;
      case (state_q)
        ST_IDLE: begin
          tx_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          if (accept) begin
            shift_q    <= tx_data;
`ifdef UART_TX_PARITY_EN
            parity_q   <= ^tx_data;
`endif
            state_q    <= ST_SYNC;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_SYNC: begin
          if (baud_tick) state_q <= ST_START;
        end
        ST_START: begin
          if (baud_tick) begin
            state_q   <= ST_DATA;
            bit_cnt_q <= '0;
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            shift_q <= shift_q >> 1;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q  <= '0;
              stop_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
              state_q    <= ST_PARITY;
`else
              state_q    <= ST_STOP;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_tick) begin
            state_q    <= ST_STOP;
            stop_cnt_q <= '0;
          end
        end
`endif
        ST_STOP: begin
          if (baud_tick) begin
            if (stop_cnt_q == LAST_STOP) begin
              state_q    <= ST_IDLE;
              tx_ready_q <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              stop_cnt_q <= stop_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          tx_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign tx        = tx_q;
  assign tx_ready  = tx_ready_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: frames are decoded off the tx line and
// matched against hand-computed frames queued at issue time (UART_TX_PARITY_EN aware).
module tb_uart_tx_serializer;
  import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
  localparam int         FL  = 11;
  localparam logic [10:0] E07 = 11'h60E;
  localparam logic [10:0] EA5 = 11'h54A;
  localparam logic [10:0] E03 = 11'h406;
  localparam logic [10:0] E3C = 11'h478;
  localparam logic [10:0] E00 = 11'h400;
  localparam logic [10:0] E5B = 11'h6B6;
`else
  localparam int         FL  = 10;
  localparam logic [10:0] E07 = 11'h20E;
  localparam logic [10:0] EA5 = 11'h34A;
  localparam logic [10:0] E03 = 11'h206;
  localparam logic [10:0] E3C = 11'h278;
  localparam logic [10:0] E00 = 11'h200;
  localparam logic [10:0] E5B = 11'h2B6;
`endif

  logic       clk_in    = 1'b0;
  logic       rst_n     = 1'b0;
  logic       baud_clk  = 1'b1;
  logic [7:0] tx_data   = 8'h00;
  logic       tx_valid  = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  tx_state_e  dbg_state;

  int   n_cmp     = 0;
  int   n_err     = 0;
  int   cyc       = 0;
  logic baud_run  = 1'b0;
  logic baud_hold = 1'b1;
  logic [10:0] exp_q[$];

  uart_tx_serializer dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .baud_clk  (baud_clk),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx        (tx),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / baud generation: baud_clk period 8 cycles, rising at negedges where cyc%8==4
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;
  always @(negedge clk_in) baud_clk = baud_run ? cyc[2] : baud_hold;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input int bound);
    int k;
    k = 0;
    while (tx_ready !== 1'b1 && k < bound) begin
      @(negedge clk_in);
      k++;
    end
    check("ready_wait", {31'b0, tx_ready}, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic [10:0] e);
    wait_ready(400);
    tx_data  = d;
    tx_valid = 1'b1;
    exp_q.push_back(e);
    @(negedge clk_in);
    tx_valid = 1'b0;
    check("accept_ready_drop", {31'b0, tx_ready}, 32'd0);
    check("accept_busy_rise", {31'b0, busy}, 32'd1);
  endtask

  // monitor
  task automatic mon_wait(input int n, output logic ab);
    ab = 1'b0;
    repeat (n) begin
      @(negedge clk_in);
      if (rst_n !== 1'b1) ab = 1'b1;
    end
  endtask

  task automatic decode_frame();
    logic [10:0] got;
    logic [10:0] e;
    logic        busy_ok;
    logic        abort;
    int          k;
    got     = '0;
    busy_ok = 1'b1;
    abort   = 1'b0;
    check("start_state", 32'(dbg_state), 32'(ST_START));
    mon_wait(3, abort);
    for (int i = 0; i < FL && !abort; i++) begin
      if (i > 0) mon_wait(8, abort);
      if (!abort) begin
        got[i] = tx;
        if (!(busy === 1'b1 && tx_ready === 1'b0)) busy_ok = 1'b0;
      end
    end
    if (!abort) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL frame_unexpected: got %0h expected none", got);
      end else begin
        e = exp_q.pop_front();
        check("frame", {21'b0, got}, {21'b0, e});
      end
      check("frame_busy", {31'b0, busy_ok}, 32'd1);
      k = 0;
      while (tx_ready !== 1'b1 && k < 8) begin
        @(negedge clk_in);
        k++;
      end
      check("ready_after_stop", {31'b0, tx_ready}, 32'd1);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_in);
      if (rst_n === 1'b1 && tx === 1'b0) decode_frame();
    end
  end

  // stimulus
  initial begin
    int k;
    int zeros;
    int m0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk_in);
    check("reset_tx", {31'b0, tx}, 32'd1);
    check("reset_ready", {31'b0, tx_ready}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk_in);
    check("ready_after_release", {31'b0, tx_ready}, 32'd1);

    // baud_clk held high since reset: no tick may start the frame
    send_byte(8'h07, E07);
    zeros = 0;
    repeat (10) begin
      @(negedge clk_in);
      if (tx !== 1'b1) zeros++;
    end
    check("no_spurious_tick", zeros, 0);
    baud_run = 1'b1;

    send_byte(8'hA5, EA5);
    send_byte(8'h03, E03);

    // tx_valid held through a busy frame
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    exp_q.push_back(E3C);
    k = 0;
    while (tx_ready !== 1'b1 && k < 400) begin
      @(negedge clk_in);
      k++;
    end
    check("held_ready_seen", {31'b0, tx_ready}, 32'd1);
    @(negedge clk_in);
    tx_valid = 1'b0;
    check("held_accepted", {31'b0, tx_ready}, 32'd0);

    // reset during data bit 3 of 8'hFF
    wait_ready(400);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk_in);
    tx_valid = 1'b0;
    k = 0;
    while (tx !== 1'b0 && k < 40) begin
      @(negedge clk_in);
      k++;
    end
    check("ff_start_seen", {31'b0, tx}, 32'd0);
    repeat (35) @(negedge clk_in);
    check("ff_bit3", {31'b0, tx}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk_in);
    check("midreset_tx", {31'b0, tx}, 32'd1);
    check("midreset_ready", {31'b0, tx_ready}, 32'd0);
    check("midreset_busy", {31'b0, busy}, 32'd0);
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    send_byte(8'h00, E00);

    // accept on the same posedge the tick is sampled (posedges where cyc becomes 0 mod 8)
    wait_ready(400);
    k = 0;
    while ((cyc % 8) != 7 && k < 16) begin
      @(negedge clk_in);
      k++;
    end
    tx_data  = 8'h5B;
    tx_valid = 1'b1;
    exp_q.push_back(E5B);
    @(negedge clk_in);
    tx_valid = 1'b0;
    m0 = cyc;
    check("coinc_accept", {31'b0, tx_ready}, 32'd0);
    repeat (5) @(negedge clk_in);
    check("coinc_sync_hold", {31'b0, tx}, 32'd1);
    repeat (4) @(negedge clk_in);
    check("coinc_start_bit", {31'b0, tx}, 32'd0);
    check("coinc_phase", cyc - m0, 9);

    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk_in);
      k++;
    end
    check("queue_drained", exp_q.size(), 0);
    repeat (10) @(negedge clk_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    repeat (20000) @(posedge clk_in);
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmit stage directly downstream of the baud-rate clock divider.
- Consumes the divider's slow square-wave output (`baud_clk`) as a bit-timing reference. Serializes one parallel byte into an 8N1 frame (optionally 8E1) on the `tx` line.
- Runs entirely in the fast system clock domain. `baud_clk` is never used as a clock, only sampled and edge-detected.

Parameters:
- DATA_BITS, 8, data bits per frame, sent LSB first (legal 5..8).
- STOP_BITS, 1, stop bit periods per frame (legal 1..2).

Ports:
- clk_in  input  1  system clock, same clock that drives the divider.
- rst_n  input  1  reset, synchronous, active-low.
- baud_clk  input  1  divider output; each rising edge marks one bit period.
- tx_data  input  DATA_BITS  byte to send.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  block can accept a byte.
- tx  output  1  serial line, idle high.
- busy  output  1  frame in progress (inverse of tx_ready, except during reset).

Behaviour:
- Clock and reset: one clock, clk_in. Reset is synchronous and active-low (rst_n); all state is sampled on posedge clk_in.
- Reset values: tx=1, tx_ready=0, busy=0, state=IDLE, bit counter=0, sync flops=0, primed=0. tx_ready rises on the first posedge with rst_n high.
- Tick generation:
  - baud_clk passes through a 2-flop synchronizer, then a rising-edge detector, producing baud_tick (1 clk_in cycle wide).
  - Latency from baud_clk edge to baud_tick is 3 clk_in cycles.
  - The edge detector discards its first sample after reset (primed flag), so a baud_clk that is high at reset release gives no spurious tick.
- Handshake:
  - A byte is accepted when tx_valid && tx_ready on a posedge.
  - tx_data is latched into the shift register; tx_ready drops and busy rises the next cycle.
  - tx_valid while busy is ignored; there is no buffering.
- States and transitions. Transitions occur only on baud_tick unless noted.
  - IDLE: tx=1, tx_ready=1. On accept -> SYNC (no tick needed).
  - SYNC: tx=1. Waits for the next tick so the start bit is a full period. Tick -> START.
  - START: tx=0. Tick -> DATA, bit_cnt=0.
  - DATA: tx=shift[0]. On each tick: shift right; bit_cnt++. After bit DATA_BITS-1 -> PARITY if enabled, else STOP.
  - STOP: tx=1 for STOP_BITS ticks, then -> IDLE, tx_ready=1.
- tx is registered and changes exactly one clk_in cycle after the state register updates. Frame length from the SYNC-exit tick is 1+DATA_BITS+STOP_BITS bit periods (+1 with parity).
- A baud_tick in the same cycle as an accept in IDLE is ignored; the block waits for the next tick.
- Reset mid-frame: on the posedge with rst_n low, tx returns to 1 and state to IDLE. The frame is truncated and the partial byte is not resent.
- bit_cnt width is $clog2(DATA_BITS+1). It wraps to 0 on leaving DATA.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: an even-parity bit (XOR-reduce of the latched byte) is inserted after the last data bit in state PARITY, lasting one tick. An 8-bit frame is 11 periods.
- Undefined: the PARITY state and parity register are absent; DATA goes straight to STOP. An 8-bit frame is 10 periods.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, SYNC, START, DATA, PARITY, STOP);
  - default DATA_BITS and STOP_BITS constants;
  - idle line level constant (1).
- One natural sub-module: baud_edge_detect (2-flop synchronizer + primed rising-edge detector, output baud_tick). The divider-facing UART receiver can reuse it.

Test Plan:
- Stimulus: baud_clk toggling every 4 clk_in cycles (period 8). Send tx_data=8'hA5 -> tx after the SYNC tick is 0,1,0,1,0,0,1,0,1,1, each bit held 8 cycles; tx_ready returns to 1 after the stop bit.
- Hold tx_valid high with tx_data=8'h3C during a frame -> the second byte is accepted only when tx_ready=1 again; frames are back-to-back with at least one SYNC wait.
- Reset at baud_clk=1 with no activity -> no baud_tick in the first 10 cycles; tx=1 and tx_ready=0 in reset, tx_ready=1 one cycle after release.
- Assert rst_n=0 during data bit 3 of 8'hFF -> tx=1 on the next posedge; after release, 8'h00 transmits cleanly as 0,0×8,1.
- With UART_TX_PARITY_EN defined: send 8'h07 -> parity bit 1 before stop. Send 8'h03 -> parity bit 0. Frame is 11 periods.
- Accept on the same cycle as a baud_tick -> the start bit begins on the following tick, not the coincident one.
